shift_pipe_unit: RTL and testbench
==================================

Name: shift_pipe_unit

Overview:
- Two-stage pipelined 16-bit shifter/rotator for the execute stage.
- Consumes an operand, a 4-bit count and an op code, and produces the shifted result two cycles later.
- Stage 1 applies the shift-by-8 and shift-by-4 positions; stage 2 applies the by-2 and by-1 positions.
- Valid/ready handshakes on both sides, so a stalled writeback back-pressures the issue logic.

Parameters:
- WIDTH, 16, operand/result width; fixed at 16, since the count is 4 bits.
- TAGW, 3, width of the opaque destination tag carried alongside each operation.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all in-flight operations (branch mispredict)
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  unit accepts the operation this cycle
- in_data  input  16  operand
- in_cnt  input  4  shift amount, 0-15
- in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRA
- in_tag  input  TAGW  destination tag, passed through unchanged
- out_valid  output  1  result available
- out_ready  input  1  downstream consumes the result
- out_data  output  16  shifted result
- out_tag  output  TAGW  tag of the result

Behaviour:
- Op semantics:
  - ROL/ROR: bits wrap around.
  - SLL: fills with zeros.
  - SRA: fills with the operand's bit 15 (original sign), at every stage.
- Count 0 on any op: out_data equals in_data.
- Stage 1 register (s1_valid, s1_data, s1_cnt[1:0], s1_op, s1_sign, s1_tag):
  - Loads on the in_valid && in_ready cycle.
  - s1_data = in_data after the shift by 8*cnt[3] + 4*cnt[2].
  - s1_sign = in_data[15].
- Stage 2 / output register (out_valid, out_data, out_tag):
  - Loads s1_data after the shift by 2*s1_cnt[1] + s1_cnt[0], using s1_sign as the SRA fill.
- Advance rules:
  - adv2 = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || adv2 (combinational; no dependency on in_valid).
- Register updates:
  - Output register: when adv2, out_valid <= 1 with new data. Otherwise, when out_ready, out_valid <= 0.
  - Stage 1: when in_valid && in_ready, s1_valid <= 1. Otherwise, when adv2, s1_valid <= 0.
- Latency and throughput:
  - 2 cycles from acceptance to out_valid.
  - One op per cycle when out_ready is held high.
- Back-pressure:
  - While out_valid && !out_ready, out_data and out_tag hold stable.
  - A second op parks in stage 1; in_ready drops only when both stages are full.
- Simultaneous consume and fill: out_ready while s1_valid → the output register is replaced in the same cycle, with no bubble.
- rst: clears s1_valid and out_valid. out_data, out_tag and all s1_* fields reset to 0. After reset, in_ready = 1.
- flush:
  - Same effect as rst on the valid bits; data registers are don't-care.
  - flush overrides an acceptance in the same cycle: the presented op is dropped, although in_ready may read 1.
  - Reset or flush mid-operation discards in-flight results; none reappear afterward.
- No X propagation: data registers update only on their load enables.

Test Plan:
- Reset, then single ops with out_ready=1:
  - ROL 0x8001 cnt 4 → 0x0018
  - SLL 0x00FF cnt 8 → 0xFF00
  - ROR 0x1234 cnt 8 → 0x3412
  - SRA 0x8000 cnt 15 → 0xFFFF
  - SRA 0x4000 cnt 3 → 0x0800
  - Each result appears with out_valid exactly 2 cycles after acceptance.
- Back-to-back stream of 16 ops (SLL 0x0001, cnt 0..15, tags cycling) with out_ready=1 → in_ready stays 1; results 0x0001..0x8000 arrive one per cycle, in order, with matching tags.
- Hold out_ready=0 while issuing 3 ops:
  - First two accepted; in_ready drops before the third.
  - out_data holds the first result unchanged.
  - Raise out_ready → all three results delivered in order, none lost or duplicated.
- Assert flush with both stages full and in_valid=1 → next cycle out_valid=0, s1 empty, in_ready=1; the flushed tags never appear on the output.
- Assert rst mid-stream, holding in_valid=1 → out_valid=0 and out_data=0x0000 the following cycle; the op held on in_valid after reset deasserts is processed normally.
- Count-0 sweep over all four ops with operand 0xA5C3 → out_data=0xA5C3 each time.

Source files
------------

// File: rtl/shift_pipe_unit.sv
// Two-stage pipelined 16-bit shifter/rotator with valid/ready handshakes.
// Stage 1 applies the by-8/by-4 positions, stage 2 the by-2/by-1 positions.
module shift_pipe_unit #(
    parameter int WIDTH = 16,
    parameter int TAGW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_cnt,
    input  logic [1:0]       in_op,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag
);

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    // SRA fill comes from the original operand sign, not the partially shifted value
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input op_e              op,
        input logic             sign,
        input logic [4:0]       k
    );
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> k) : '0;
        unique case (op)
            OP_ROL: shift_by = (d << k) | (d >> (5'd16 - k));
            OP_SLL: shift_by = d << k;
            OP_ROR: shift_by = (d >> k) | (d << (5'd16 - k));
            OP_SRA: shift_by = (d >> k) | fill;
        endcase
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [1:0]       s1_cnt;
    op_e              s1_op;
    logic             s1_sign;
    logic [TAGW-1:0]  s1_tag;

    op_e              op_in;
    logic [WIDTH-1:0] st1_a, st1_res;
    logic [WIDTH-1:0] st2_a, st2_res;
    logic             adv2, acc;

    always_comb begin
        op_in   = op_e'(in_op);
        st1_a   = in_cnt[3] ? shift_by(in_data, op_in, in_data[WIDTH-1], 5'd8) : in_data;
        st1_res = in_cnt[2] ? shift_by(st1_a, op_in, in_data[WIDTH-1], 5'd4) : st1_a;
        st2_a   = s1_cnt[1] ? shift_by(s1_data, s1_op, s1_sign, 5'd2) : s1_data;
        st2_res = s1_cnt[0] ? shift_by(st2_a, s1_op, s1_sign, 5'd1) : st2_a;
    end

    assign adv2     = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || adv2;
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_cnt    <= '0;
            s1_op     <= OP_ROL;
            s1_sign   <= 1'b0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else begin
            // flush only kills the valid bits; data loads below are don't-care then
            if (flush) begin
                s1_valid  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (acc)
                    s1_valid <= 1'b1;
                else if (adv2)
                    s1_valid <= 1'b0;
                if (adv2)
                    out_valid <= 1'b1;
                else if (out_ready)
                    out_valid <= 1'b0;
            end
            if (acc) begin
                s1_data <= st1_res;
                s1_cnt  <= in_cnt[1:0];
                s1_op   <= op_in;
                s1_sign <= in_data[WIDTH-1];
                s1_tag  <= in_tag;
            end
            if (adv2) begin
                out_data <= st2_res;
                out_tag  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Directed plus randomized bench for shift_pipe_unit against a bitwise reference
// model with a two-slot occupancy tracker.
module tb_shift_pipe_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic [2:0]  in_tag, out_tag;

    int n_vec = 0;
    int n_err = 0;

    // model state: expected final result held in each slot
    logic        m_s1v = 1'b0, m_outv = 1'b0, m_known = 1'b0;
    logic [15:0] m_s1d = '0, m_outd = '0;
    logic [2:0]  m_s1t = '0, m_outt = '0;
    logic        last_acc;

    shift_pipe_unit #(.WIDTH(16), .TAGW(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_cnt(in_cnt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int cnt, input int op);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            case (op)
                0: r[i] = d[(i - cnt + 16) % 16];
                1: r[i] = (i >= cnt) ? d[i - cnt] : 1'b0;
                2: r[i] = d[(i + cnt) % 16];
                default: r[i] = (i + cnt < 16) ? d[i + cnt] : d[15];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // one clock cycle with the currently driven inputs
    task automatic step();
        logic        exp_rdy, adv, acc;
        logic [15:0] res;
        #1;
        exp_rdy = !m_s1v || !m_outv || out_ready;
        if (!rst) chk("in_ready", in_ready, exp_rdy);
        adv = m_s1v && (!m_outv || out_ready);
        acc = in_valid && exp_rdy && !rst && !flush;
        res = ref_shift(in_data, int'(in_cnt), int'(in_op));
        @(posedge clk);
        #1;
        if (rst) begin
            m_s1v = 0; m_outv = 0; m_outd = '0; m_outt = '0; m_known = 1;
        end else if (flush) begin
            m_s1v = 0; m_outv = 0; m_known = 0;
        end else begin
            if (adv) begin
                m_outv = 1; m_outd = m_s1d; m_outt = m_s1t; m_known = 1;
            end else if (out_ready) m_outv = 0;
            if (acc) begin
                m_s1v = 1; m_s1d = res; m_s1t = in_tag;
            end else if (adv) m_s1v = 0;
        end
        last_acc = acc;
        chk("out_valid", out_valid, m_outv);
        if (m_outv || m_known) begin
            chk("out_data", out_data, m_outd);
            if (m_outv || rst) chk("out_tag", out_tag, m_outt);
        end
    endtask

    // present an op until accepted, bounded
    task automatic issue(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op, input logic [2:0] t);
        int n;
        in_valid = 1; in_data = d; in_cnt = c; in_op = op; in_tag = t;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) chk("accept_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 1;
        in_data = '0; in_cnt = '0; in_op = '0; in_tag = '0;
        step(); step();
        rst = 0;
        idle(1);

        // single ops; directed expectations also checked against constants
        issue(16'h8001, 4'd4, 2'b00, 3'd1); idle(1); chk("rol_8001_4", out_data, 16'h0018); idle(1);
        issue(16'h00FF, 4'd8, 2'b01, 3'd2); idle(1); chk("sll_00ff_8", out_data, 16'hFF00); idle(1);
        issue(16'h1234, 4'd8, 2'b10, 3'd3); idle(1); chk("ror_1234_8", out_data, 16'h3412); idle(1);
        issue(16'h8000, 4'd15, 2'b11, 3'd4); idle(1); chk("sra_8000_15", out_data, 16'hFFFF); idle(1);
        issue(16'h4000, 4'd3, 2'b11, 3'd5); idle(1); chk("sra_4000_3", out_data, 16'h0800); idle(1);

        // back-to-back stream
        for (int i = 0; i < 16; i++) issue(16'h0001, 4'(i), 2'b01, 3'(i));
        idle(3);

        // back-pressure: three ops with out_ready low, then drain
        out_ready = 0;
        issue(16'hBEEF, 4'd5, 2'b00, 3'd1);
        issue(16'hC0DE, 4'd9, 2'b11, 3'd2);
        in_valid = 1; in_data = 16'h1357; in_cnt = 4'd6; in_op = 2'b10; in_tag = 3'd3;
        step(); step(); step();
        out_ready = 1;
        issue(16'h1357, 4'd6, 2'b10, 3'd3);
        idle(4);

        // flush with both stages full and an op presented
        out_ready = 0;
        issue(16'h1111, 4'd1, 2'b01, 3'd6);
        issue(16'h2222, 4'd2, 2'b01, 3'd7);
        in_valid = 1; in_data = 16'h3333; in_cnt = 4'd3; in_tag = 3'd5;
        flush = 1; step(); flush = 0; in_valid = 0;
        out_ready = 1;
        idle(4);

        // reset mid-stream, op held across reset release
        issue(16'hF00F, 4'd7, 2'b00, 3'd2);
        in_valid = 1; in_data = 16'h8421; in_cnt = 4'd10; in_op = 2'b11; in_tag = 3'd4;
        rst = 1; step(); rst = 0;
        step(); in_valid = 0;
        idle(3);

        // count-0 sweep
        for (int op = 0; op < 4; op++) begin
            issue(16'hA5C3, 4'd0, 2'(op), 3'(op));
            idle(1);
            chk("cnt0", out_data, 16'hA5C3);
        end
        idle(2);

        // random traffic with occasional flush/reset
        for (int i = 0; i < 500; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 39) == 0;
            rst       = $urandom_range(0, 99) == 0;
            in_data   = 16'($urandom);
            in_cnt    = 4'($urandom);
            in_op     = 2'($urandom);
            in_tag    = 3'($urandom);
            step();
        end
        rst = 0; flush = 0; out_ready = 1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
